// File: rtl/mips_main_controller_if.sv
// Control bus between the multicycle MIPS datapath and its main controller.
// The controller side uses the slave modport; the datapath side drives the master.
interface mips_main_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       pcen;
    logic [3:0] state;

    modport master (
        output opcode, funct, zero, mem_ready,
        input  iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
               alusrcb, pcsrc, alucontrol, pcen, state
    );

    modport slave (
        input  opcode, funct, zero, mem_ready,
        output iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
               alusrcb, pcsrc, alucontrol, pcen, state
    );
endinterface

// File: rtl/mips_main_controller.sv
// Main control FSM for a multicycle MIPS datapath with wait-state memory.
// All outputs are decoded combinationally from the current state (plus zero/mem_ready).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instruction at PC, PC+4 -> PC when memory completes
// DECODE   | read registers, compute branch target, dispatch on opcode
// MEMADR   | compute base + offset for lw/sw
// MEMRD    | read data memory, wait for completion
// MEMWB    | write loaded data to rt
// MEMWR    | write data memory, wait for completion
// EXECUTE  | R-type ALU operation selected by funct
// ALUWB    | write ALU result to rd
// BRANCH   | compare for beq, take target when zero
// ADDIEX   | rs + sign-extended immediate
// ADDIWB   | write addi result to rt
// JUMP     | load jump target into PC
module mips_main_controller (
    input  logic                   clk,
    input  logic                   reset,
    mips_main_controller_if.slave  bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    state_t     state_q;
    state_t     state_d;
    aluop_t     aluop;
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = S_FETCH;
        aluop    = ALUOP_ADD;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;

        if (reset) begin
            // Hold the FETCH selects with every enable off, whatever state we were in.
            alusrcb = 2'b01;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    alusrcb = 2'b01;
                    irwrite = bus.mem_ready;
                    pcwrite = bus.mem_ready;
                    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                    unique case (bus.opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXECUTE;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    iord    = 1'b1;
                    state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                S_MEMWR: begin
                    iord     = 1'b1;
                    memwrite = bus.mem_ready;
                    state_d  = bus.mem_ready ? S_FETCH : S_MEMWR;
                end
                S_EXECUTE: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_FUNCT;
                    state_d = S_ALUWB;
                end
                S_ALUWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                S_BRANCH: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_SUB;
                    pcsrc   = 2'b01;
                    branch  = 1'b1;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    state_d = S_ADDIWB;
                end
                S_ADDIWB: begin
                    regwrite = 1'b1;
                end
                S_JUMP: begin
                    pcsrc   = 2'b10;
                    pcwrite = 1'b1;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_comb begin
        alucontrol = 3'b010;
        unique case (aluop)
            ALUOP_SUB: alucontrol = 3'b110;
            ALUOP_FUNCT: begin
                unique case (bus.funct)
                    FN_ADD:  alucontrol = 3'b010;
                    FN_SUB:  alucontrol = 3'b110;
                    FN_AND:  alucontrol = 3'b000;
                    FN_OR:   alucontrol = 3'b001;
                    FN_SLT:  alucontrol = 3'b111;
                    default: alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    assign bus.iord       = iord;
    assign bus.irwrite    = irwrite;
    assign bus.memwrite   = memwrite;
    assign bus.regwrite   = regwrite;
    assign bus.regdst     = regdst;
    assign bus.memtoreg   = memtoreg;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.pcsrc      = pcsrc;
    assign bus.alucontrol = alucontrol;
    assign bus.pcen       = pcwrite | (branch & bus.zero);
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_main_controller.sv
// Directed bench for the multicycle MIPS main controller: walks each
// instruction class, memory wait states and reset mid-instruction.
module tb_mips_main_controller;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    mips_main_controller_if bus_if ();

    mips_main_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus_if.opcode    = 6'b000000;
        bus_if.funct     = 6'b000000;
        bus_if.zero      = 1'b0;
        bus_if.mem_ready = 1'b1;
        tick();
        tick();
        chk("rst_state",   bus_if.state, 4'd0);
        chk("rst_irwrite", {3'b0, bus_if.irwrite}, 4'd0);
        chk("rst_pcen",    {3'b0, bus_if.pcen}, 4'd0);
        chk("rst_alusrcb", {2'b0, bus_if.alusrcb}, 4'd1);
        chk("rst_aluctl",  {1'b0, bus_if.alucontrol}, 4'd2);

        // lw, zero-wait memory
        reset         = 1'b0;
        bus_if.opcode = 6'b100011;
        #1;
        chk("lw_fetch_state",   bus_if.state, 4'd0);
        chk("lw_fetch_irwrite", {3'b0, bus_if.irwrite}, 4'd1);
        chk("lw_fetch_pcen",    {3'b0, bus_if.pcen}, 4'd1);
        chk("lw_fetch_regwr",   {3'b0, bus_if.regwrite}, 4'd0);
        tick();
        chk("lw_dec_state",   bus_if.state, 4'd1);
        chk("lw_dec_alusrcb", {2'b0, bus_if.alusrcb}, 4'd3);
        chk("lw_dec_pcen",    {3'b0, bus_if.pcen}, 4'd0);
        tick();
        chk("lw_adr_state",   bus_if.state, 4'd2);
        chk("lw_adr_alusrca", {3'b0, bus_if.alusrca}, 4'd1);
        chk("lw_adr_alusrcb", {2'b0, bus_if.alusrcb}, 4'd2);
        tick();
        chk("lw_rd_state",  bus_if.state, 4'd3);
        chk("lw_rd_iord",   {3'b0, bus_if.iord}, 4'd1);
        chk("lw_rd_regwr",  {3'b0, bus_if.regwrite}, 4'd0);
        chk("lw_rd_m2r",    {3'b0, bus_if.memtoreg}, 4'd0);
        tick();
        chk("lw_wb_state", bus_if.state, 4'd4);
        chk("lw_wb_regwr", {3'b0, bus_if.regwrite}, 4'd1);
        chk("lw_wb_m2r",   {3'b0, bus_if.memtoreg}, 4'd1);
        chk("lw_wb_regdst", {3'b0, bus_if.regdst}, 4'd0);
        tick();
        chk("lw_done_state", bus_if.state, 4'd0);

        // FETCH holds while memory is busy
        bus_if.mem_ready = 1'b0;
        bus_if.opcode    = 6'b000100;
        #1;
        chk("fwait_irwrite", {3'b0, bus_if.irwrite}, 4'd0);
        chk("fwait_pcen",    {3'b0, bus_if.pcen}, 4'd0);
        tick();
        chk("fwait_state", bus_if.state, 4'd0);
        bus_if.mem_ready = 1'b1;
        tick();

        // beq, taken then not taken
        chk("beq_dec_state", bus_if.state, 4'd1);
        tick();
        bus_if.zero = 1'b1;
        #1;
        chk("beq_state",   bus_if.state, 4'd8);
        chk("beq_t_pcen",  {3'b0, bus_if.pcen}, 4'd1);
        chk("beq_pcsrc",   {2'b0, bus_if.pcsrc}, 4'd1);
        chk("beq_aluctl",  {1'b0, bus_if.alucontrol}, 4'd6);
        bus_if.zero = 1'b0;
        #1;
        chk("beq_nt_pcen", {3'b0, bus_if.pcen}, 4'd0);
        tick();
        chk("beq_done_state", bus_if.state, 4'd0);

        // R-type: slt, plus the other funct codes while in EXECUTE
        bus_if.opcode = 6'b000000;
        bus_if.funct  = 6'b101010;
        tick();
        tick();
        chk("r_ex_state",   bus_if.state, 4'd6);
        chk("r_slt_aluctl", {1'b0, bus_if.alucontrol}, 4'd7);
        chk("r_ex_alusrca", {3'b0, bus_if.alusrca}, 4'd1);
        chk("r_ex_alusrcb", {2'b0, bus_if.alusrcb}, 4'd0);
        bus_if.funct = 6'b100100;
        #1;
        chk("r_and_aluctl", {1'b0, bus_if.alucontrol}, 4'd0);
        bus_if.funct = 6'b100101;
        #1;
        chk("r_or_aluctl", {1'b0, bus_if.alucontrol}, 4'd1);
        bus_if.funct = 6'b100010;
        #1;
        chk("r_sub_aluctl", {1'b0, bus_if.alucontrol}, 4'd6);
        bus_if.funct = 6'b111111;
        #1;
        chk("r_other_aluctl", {1'b0, bus_if.alucontrol}, 4'd2);
        tick();
        chk("r_wb_state",  bus_if.state, 4'd7);
        chk("r_wb_regdst", {3'b0, bus_if.regdst}, 4'd1);
        chk("r_wb_regwr",  {3'b0, bus_if.regwrite}, 4'd1);
        chk("r_wb_m2r",    {3'b0, bus_if.memtoreg}, 4'd0);
        tick();
        chk("r_done_state", bus_if.state, 4'd0);

        // sw with three memory wait cycles
        bus_if.opcode = 6'b101011;
        tick();
        tick();
        tick();
        bus_if.mem_ready = 1'b0;
        #1;
        chk("sw_w1_state", bus_if.state, 4'd5);
        chk("sw_w1_memwr", {3'b0, bus_if.memwrite}, 4'd0);
        chk("sw_w1_iord",  {3'b0, bus_if.iord}, 4'd1);
        tick();
        chk("sw_w2_state", bus_if.state, 4'd5);
        chk("sw_w2_memwr", {3'b0, bus_if.memwrite}, 4'd0);
        tick();
        chk("sw_w3_state", bus_if.state, 4'd5);
        chk("sw_w3_memwr", {3'b0, bus_if.memwrite}, 4'd0);
        tick();
        bus_if.mem_ready = 1'b1;
        #1;
        chk("sw_w4_state", bus_if.state, 4'd5);
        chk("sw_w4_memwr", {3'b0, bus_if.memwrite}, 4'd1);
        tick();
        chk("sw_done_state", bus_if.state, 4'd0);

        // addi
        bus_if.opcode = 6'b001000;
        tick();
        tick();
        chk("addi_ex_state",   bus_if.state, 4'd9);
        chk("addi_ex_alusrcb", {2'b0, bus_if.alusrcb}, 4'd2);
        chk("addi_ex_aluctl",  {1'b0, bus_if.alucontrol}, 4'd2);
        tick();
        chk("addi_wb_state",  bus_if.state, 4'd10);
        chk("addi_wb_regwr",  {3'b0, bus_if.regwrite}, 4'd1);
        chk("addi_wb_regdst", {3'b0, bus_if.regdst}, 4'd0);
        tick();
        chk("addi_done_state", bus_if.state, 4'd0);

        // j
        bus_if.opcode = 6'b000010;
        tick();
        tick();
        chk("j_state", bus_if.state, 4'd11);
        chk("j_pcen",  {3'b0, bus_if.pcen}, 4'd1);
        chk("j_pcsrc", {2'b0, bus_if.pcsrc}, 4'd2);
        tick();
        chk("j_done_state", bus_if.state, 4'd0);

        // undefined opcode
        bus_if.opcode = 6'b111111;
        tick();
        chk("undef_dec_state", bus_if.state, 4'd1);
        chk("undef_regwr",     {3'b0, bus_if.regwrite}, 4'd0);
        chk("undef_memwr",     {3'b0, bus_if.memwrite}, 4'd0);
        chk("undef_pcen",      {3'b0, bus_if.pcen}, 4'd0);
        tick();
        chk("undef_next_state", bus_if.state, 4'd0);

        // reset during MEMRD
        bus_if.opcode = 6'b100011;
        tick();
        tick();
        tick();
        chk("rmid_pre_state", bus_if.state, 4'd3);
        reset = 1'b1;
        #1;
        chk("rmid_iord",     {3'b0, bus_if.iord}, 4'd0);
        chk("rmid_irwrite",  {3'b0, bus_if.irwrite}, 4'd0);
        chk("rmid_pcen",     {3'b0, bus_if.pcen}, 4'd0);
        chk("rmid_alusrcb",  {2'b0, bus_if.alusrcb}, 4'd1);
        tick();
        chk("rmid_state",    bus_if.state, 4'd0);
        chk("rmid_regwr",    {3'b0, bus_if.regwrite}, 4'd0);
        reset = 1'b0;
        #1;
        chk("rmid_rel_irwrite", {3'b0, bus_if.irwrite}, 4'd1);
        tick();
        chk("rmid_rel_state", bus_if.state, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
